bcd_updown_counter: RTL and testbench
=====================================

Name: bcd_updown_counter

Overview:
- Parametrised multi-digit BCD up/down counter; successor to the fixed 3-digit display counter.
- Drives the Segment7 digit multiplexer with a packed BCD bus.
- Adds count enable, wrap/saturate mode, terminal-count and overflow flags.
- Holds one decimal count of DIGITS digits; digit 0 is least significant.

Parameters:
- DIGITS, 4, number of BCD digits (1..8); count range 0 .. 10^DIGITS-1.
- STEP_ONE_ONLY, 1, reserved; must be 1 (increment/decrement by one only); any other value is a synthesis error.

Ports:
- CE  input  1  clock; all state updates on posedge CE.
- RESET  input  1  synchronous, active-high reset.
- EN  input  1  count enable; count changes only when EN=1.
- REVERSE  input  1  0 = count up, 1 = count down; sampled each edge.
- WRAP  input  1  1 = roll over at the limits, 0 = saturate at the limits.
- CNT  output  4*DIGITS  packed BCD count; CNT[4k+3:4k] = digit k.
- TC  output  1  registered; 1 while CNT is at the terminal value for the current direction (all 9s up, all 0s down).
- OVF  output  1  registered one-cycle pulse when a roll-over or saturation-blocked step occurs.

Behaviour:
- All outputs are registers; there is no combinational path from inputs to outputs.
- Reset (RESET=1 at posedge CE; has priority over everything):
  - REVERSE=0: CNT = all 0s, TC=0.
  - REVERSE=1: CNT = all 9s, TC=0.
  - OVF=0 in both cases.
- Hold: RESET=0, EN=0 → CNT and TC unchanged; OVF=0.
- Count up (EN=1, REVERSE=0):
  - Digit 0 increments.
  - A digit at 9 becomes 0 and carries into the next digit; the carry ripples combinationally through all digits within the same cycle.
  - If all digits are 9: WRAP=1 → CNT = all 0s, OVF=1; WRAP=0 → CNT unchanged, OVF=1.
- Count down (EN=1, REVERSE=1):
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - If all digits are 0: WRAP=1 → CNT = all 9s, OVF=1; WRAP=0 → CNT unchanged, OVF=1.
- OVF is high for exactly the cycle after the boundary step. Consecutive saturated steps give OVF=1 on every such cycle.
- TC is computed from the next CNT value and the current REVERSE, and registered with CNT. TC therefore updates on the same edge as CNT. A REVERSE change with EN=0 still updates TC on the next edge.
- Direction change mid-count is legal: it takes effect on the next enabled edge, with no reload.
- Each digit only ever holds 0..9. If a digit is 10..15 (only possible via the load feature, which prevents it), up-count forces it to 0 with carry and down-count forces it to 9.
- Width rule: each digit is computed as its own 4-bit value. Binary carries never propagate between digit nibbles.

Optional Feature:
- Macro: BCD_COUNTER_LOAD_EN.
- Defined: adds ports LOAD (input, 1) and LOAD_VAL (input, 4*DIGITS).
  - When RESET=0 and LOAD=1, CNT = LOAD_VAL on the next edge, independent of EN.
  - Any LOAD_VAL digit above 9 is clamped to 9.
  - OVF=0; TC is recomputed.
  - Priority: RESET > LOAD > EN count.
- Not defined: no LOAD/LOAD_VAL ports and no load logic; behaviour otherwise identical.

Test Plan:
- DIGITS=3, RESET with REVERSE=0, then 1000 enabled up edges with WRAP=1 → CNT walks 000..999 in order; 1000th edge gives CNT=000, OVF=1 for one cycle; TC=1 only while CNT=999.
- DIGITS=3, RESET with REVERSE=1 → CNT=999; one down edge → 998; from 100, one down edge → 099 (borrow across two digits).
- DIGITS=4, WRAP=0, REVERSE=0, count to 9999, then 3 more enabled edges → CNT stays 9999, OVF=1 on each of the 3 cycles, TC=1 throughout.
- DIGITS=4, CNT=0129: EN=0 for 5 edges → CNT=0129, OVF=0. Then EN=1, REVERSE toggling 0,1,0 → 0130, 0129, 0130.
- RESET asserted while EN=1 at CNT=0567, REVERSE=0 → next edge CNT=0000, OVF=0 (reset beats count).
- With BCD_COUNTER_LOAD_EN, DIGITS=4: LOAD=1, LOAD_VAL=0x12AF, EN=1 → CNT=1299. Next enabled up edge → 1300. LOAD and RESET asserted together → CNT=0000.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - parametrised multi-digit BCD up/down counter
//
// Holds one decimal count of DIGITS BCD digits (digit 0 least significant)
// and drives the Segment7 digit multiplexer with a packed BCD bus.
// Optional parallel load is compiled in when BCD_COUNTER_LOAD_EN is defined.
//
// Ports:
//   CE        in   1         clock, all state updates on rising edge
//   RESET     in   1         synchronous active-high reset
//   EN        in   1         count enable
//   REVERSE   in   1         0 = up, 1 = down
//   WRAP      in   1         1 = roll over at limits, 0 = saturate
//   LOAD      in   1         (BCD_COUNTER_LOAD_EN) load LOAD_VAL next edge
//   LOAD_VAL  in   4*DIGITS  (BCD_COUNTER_LOAD_EN) packed BCD load value
//   CNT       out  4*DIGITS  packed BCD count, CNT[4k+3:4k] = digit k
//   TC        out  1         terminal count for current direction
//   OVF       out  1         one-cycle pulse after a wrap or blocked step

module bcd_updown_counter #(
  parameter int DIGITS        = 4,
  parameter int STEP_ONE_ONLY = 1
) (
  input  logic                  CE,
  input  logic                  RESET,
  input  logic                  EN,
  input  logic                  REVERSE,
  input  logic                  WRAP,
`ifdef BCD_COUNTER_LOAD_EN
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
`endif
  output logic [4*DIGITS-1:0]   CNT,
  output logic                  TC,
  output logic                  OVF
);

  localparam int              W    = 4 * DIGITS;
  localparam logic [W-1:0]    ALL9 = {DIGITS{4'h9}};

  // Only single-step counting is implemented; reject anything else at build time.
  if (STEP_ONE_ONLY != 1) begin : g_bad_step
    $error("bcd_updown_counter: STEP_ONE_ONLY must be 1");
  end
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bcd_updown_counter: DIGITS must be 1..8");
  end

  logic [W-1:0] up_val;
  logic [W-1:0] dn_val;
  logic         up_carry;
  logic         dn_borrow;
  logic [W-1:0] cnt_nxt;
  logic         tc_nxt;
  logic         ovf_nxt;

  // Per-digit increment/decrement with a rippling decimal carry/borrow.
  // Each nibble is computed on its own so binary carries never cross digits.
  // After the loop, up_carry/dn_borrow set means every digit was at its
  // limit, i.e. the whole count is at the boundary.
  always_comb begin : step_chain
    up_val    = '0;
    dn_val    = '0;
    up_carry  = 1'b1;
    dn_borrow = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (up_carry) begin
        // 9 (or an illegal 10..15) rolls to 0 and keeps carrying
        if (CNT[4*k +: 4] >= 4'd9) begin
          up_val[4*k +: 4] = 4'd0;
        end else begin
          up_val[4*k +: 4] = CNT[4*k +: 4] + 4'd1;
          up_carry         = 1'b0;
        end
      end else begin
        up_val[4*k +: 4] = CNT[4*k +: 4];
      end

      if (dn_borrow) begin
        if (CNT[4*k +: 4] == 4'd0) begin
          dn_val[4*k +: 4] = 4'd9;
        end else if (CNT[4*k +: 4] > 4'd9) begin
          // illegal digit is forced to 9, borrow is absorbed
          dn_val[4*k +: 4] = 4'd9;
          dn_borrow        = 1'b0;
        end else begin
          dn_val[4*k +: 4] = CNT[4*k +: 4] - 4'd1;
          dn_borrow        = 1'b0;
        end
      end else begin
        dn_val[4*k +: 4] = CNT[4*k +: 4];
      end
    end
  end

`ifdef BCD_COUNTER_LOAD_EN
  logic [W-1:0] load_clamped;

  always_comb begin : load_clamp
    load_clamped = '0;
    for (int k = 0; k < DIGITS; k++) begin
      load_clamped[4*k +: 4] = (LOAD_VAL[4*k +: 4] > 4'd9) ? 4'd9 : LOAD_VAL[4*k +: 4];
    end
  end
`endif

  always_comb begin : next_state
    cnt_nxt = CNT;
    ovf_nxt = 1'b0;
`ifdef BCD_COUNTER_LOAD_EN
    if (LOAD) begin
      cnt_nxt = load_clamped;
    end else
`endif
    if (EN) begin
      if (!REVERSE) begin
        if (up_carry) begin
          // boundary: flag it, move only when wrapping (up_val is all 0s)
          ovf_nxt = 1'b1;
          if (WRAP) cnt_nxt = up_val;
        end else begin
          cnt_nxt = up_val;
        end
      end else begin
        if (dn_borrow) begin
          ovf_nxt = 1'b1;
          if (WRAP) cnt_nxt = dn_val;
        end else begin
          cnt_nxt = dn_val;
        end
      end
    end
    // TC follows the value being registered and the direction seen this edge
    tc_nxt = REVERSE ? (cnt_nxt == '0) : (cnt_nxt == ALL9);
  end

  always_ff @(posedge CE) begin
    if (RESET) begin
      CNT <= REVERSE ? ALL9 : '0;
      TC  <= 1'b0;
      OVF <= 1'b0;
    end else begin
      CNT <= cnt_nxt;
      TC  <= tc_nxt;
      OVF <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - self-checking bench for bcd_updown_counter

module tb_bcd_updown_counter;

  logic        clk;
  logic        rst;
  logic        en;
  logic        rev;
  logic        wrap;
  logic [15:0] cnt4;
  logic        tc4;
  logic        ovf4;
  logic [11:0] cnt3;
  logic        tc3;
  logic        ovf3;
`ifdef BCD_COUNTER_LOAD_EN
  logic        load;
  logic [15:0] load_val;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  bcd_updown_counter #(.DIGITS(4), .STEP_ONE_ONLY(1)) u4 (
    .CE(clk), .RESET(rst), .EN(en), .REVERSE(rev), .WRAP(wrap),
`ifdef BCD_COUNTER_LOAD_EN
    .LOAD(load), .LOAD_VAL(load_val),
`endif
    .CNT(cnt4), .TC(tc4), .OVF(ovf4)
  );

  bcd_updown_counter #(.DIGITS(3), .STEP_ONE_ONLY(1)) u3 (
    .CE(clk), .RESET(rst), .EN(en), .REVERSE(rev), .WRAP(wrap),
`ifdef BCD_COUNTER_LOAD_EN
    .LOAD(load), .LOAD_VAL(load_val[11:0]),
`endif
    .CNT(cnt3), .TC(tc3), .OVF(ovf3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        e;
    logic        v;
    logic        w;
    logic [15:0] cnt;
    logic        tc;
    logic        ovf;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [31:0] to_bcd(input int value);
    logic [31:0] res;
    int x;
    res = '0;
    x   = value;
    for (int d = 0; d < 8; d++) begin
      res[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return res;
  endfunction

  task automatic step(input logic r, input logic e, input logic v, input logic w);
    rst  = r;
    en   = e;
    rev  = v;
    wrap = w;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] ac, input logic [31:0] ec,
                       input logic at, input logic et, input logic ao, input logic eo);
    n_cmp++;
    if (ac !== ec || at !== et || ao !== eo) begin
      n_bad++;
      $display("FAIL %s: got cnt=%h tc=%b ovf=%b, want cnt=%h tc=%b ovf=%b",
               name, ac, at, ao, ec, et, eo);
    end
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    rev  = 1'b0;
    wrap = 1'b1;
`ifdef BCD_COUNTER_LOAD_EN
    load     = 1'b0;
    load_val = '0;
`endif

    // {reset, en, reverse, wrap, cnt, tc, ovf} on the 4-digit counter
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h9998, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h9998, 1'b0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].r, vecs[i].e, vecs[i].v, vecs[i].w);
      check($sformatf("vec%0d", i), {16'h0, cnt4}, {16'h0, vecs[i].cnt},
            tc4, vecs[i].tc, ovf4, vecs[i].ovf);
    end

    // 3 digits: full up walk 000..999 then wrap
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("d3_reset_up", {20'h0, cnt3}, 32'h0, tc3, 1'b0, ovf3, 1'b0);
    for (int i = 1; i <= 1000; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      if (i < 1000)
        check($sformatf("d3_walk%0d", i), {20'h0, cnt3}, to_bcd(i),
              tc3, (i == 999), ovf3, 1'b0);
      else
        check("d3_wrap", {20'h0, cnt3}, 32'h0, tc3, 1'b0, ovf3, 1'b1);
    end
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("d3_after_wrap", {20'h0, cnt3}, 32'h1, tc3, 1'b0, ovf3, 1'b0);

    // 3 digits: reset downward, borrow across two digits
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check("d3_reset_dn", {20'h0, cnt3}, 32'h999, tc3, 1'b0, ovf3, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("d3_998", {20'h0, cnt3}, 32'h998, tc3, 1'b0, ovf3, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    check("d3_100", {20'h0, cnt3}, 32'h100, tc3, 1'b0, ovf3, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("d3_099", {20'h0, cnt3}, 32'h099, tc3, 1'b0, ovf3, 1'b0);

    // 4 digits: hold, direction toggles, reset beats count
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 129; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    check("d4_0129", {16'h0, cnt4}, 32'h0129, tc4, 1'b0, ovf4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("d4_hold%0d", i), {16'h0, cnt4}, 32'h0129, tc4, 1'b0, ovf4, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("d4_dir_up", {16'h0, cnt4}, 32'h0130, tc4, 1'b0, ovf4, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("d4_dir_dn", {16'h0, cnt4}, 32'h0129, tc4, 1'b0, ovf4, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("d4_dir_up2", {16'h0, cnt4}, 32'h0130, tc4, 1'b0, ovf4, 1'b0);
    for (int i = 0; i < 437; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    check("d4_0567", {16'h0, cnt4}, 32'h0567, tc4, 1'b0, ovf4, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("d4_rst_beats_en", {16'h0, cnt4}, 32'h0, tc4, 1'b0, ovf4, 1'b0);

    // 4 digits: count to 9999 with saturation, then three blocked steps
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 9999; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      if (i == 5000)
        check("d4_5000", {16'h0, cnt4}, to_bcd(i), tc4, 1'b0, ovf4, 1'b0);
    end
    check("d4_9999", {16'h0, cnt4}, 32'h9999, tc4, 1'b1, ovf4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check($sformatf("d4_sat%0d", i), {16'h0, cnt4}, 32'h9999, tc4, 1'b1, ovf4, 1'b1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("d4_sat_release", {16'h0, cnt4}, 32'h9999, tc4, 1'b1, ovf4, 1'b0);

`ifdef BCD_COUNTER_LOAD_EN
    load     = 1'b1;
    load_val = 16'h12AF;
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("ld_clamp", {16'h0, cnt4}, 32'h1299, tc4, 1'b0, ovf4, 1'b0);
    load = 1'b0;
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("ld_next", {16'h0, cnt4}, 32'h1300, tc4, 1'b0, ovf4, 1'b0);
    load = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("ld_rst_prio", {16'h0, cnt4}, 32'h0, tc4, 1'b0, ovf4, 1'b0);
    load = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
